fnd_display_scheduler: RTL and testbench

- Arbitrates the shared 3-digit FND display between three sources: one-shot message/error codes, level-requested status patterns, and the background current-page number.
- Owns the digit-scan timing and presents the selected 12-bit word one nibble at a time to the segment decoder.
- Replaces fixed source muxing with a priority scheduler that enforces a minimum message hold and tear-free frame updates.

---
 rtl/fnd_display_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_fnd_display_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_display_scheduler.sv
// ---------------------------------------------------------------------------
// fnd_display_scheduler
//
// Purpose:
//   Shares one 3-digit FND display between three sources, highest priority
//   first: one-shot message/error codes (4-phase MSG_REQ/MSG_ACK handshake
//   with a guaranteed minimum hold), level-requested status patterns, and
//   the background page number. The block also owns the digit scan and
//   presents the displayed 12-bit word one nibble per digit slot. The
//   displayed word only changes at a frame boundary, so digits from two
//   different words are never mixed on the display.
//
// Ports:
//   MCLK          in   1   clock (48 MHz nominal)
//   nRESET        in   1   asynchronous active-low reset
//   MSG_REQ       in   1   message request, 4-phase with MSG_ACK
//   MSG_DATA      in  12   message word, captured when the request is accepted
//   MSG_ACK       out  1   message hold complete
//   STAT_REQ      in   1   status request, level sensitive
//   STAT_DATA     in  12   status word, live
//   PAGE_DATA     in  12   background page word, live
//   DISP_VALUE    out 12   word currently on display
//   DISP_SRC      out  2   source of DISP_VALUE: 00 page, 01 status, 10 message
//   nDIGIT        out  3   active-low anode select (011 -> 101 -> 110)
//   DIGIT_NIBBLE  out  4   nibble for the currently selected digit
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fnd_display_scheduler #(
  parameter int SCAN_DIV    = 1024,
  parameter int HOLD_CYCLES = 12000000
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        MSG_REQ,
  input  logic [11:0] MSG_DATA,
  output logic        MSG_ACK,
  input  logic        STAT_REQ,
  input  logic [11:0] STAT_DATA,
  input  logic [11:0] PAGE_DATA,
  output logic [11:0] DISP_VALUE,
  output logic [1:0]  DISP_SRC,
  output logic [2:0]  nDIGIT,
  output logic [3:0]  DIGIT_NIBBLE
);

  // HOLD_CYCLES+1 keeps the width non-zero when HOLD_CYCLES is 1.
  localparam int ScanW = $clog2(SCAN_DIV);
  localparam int HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  localparam logic [2:0] DigHi  = 3'b011;
  localparam logic [2:0] DigMid = 3'b101;
  localparam logic [2:0] DigLo  = 3'b110;

  localparam logic [1:0] SrcPage = 2'b00;
  localparam logic [1:0] SrcStat = 2'b01;
  localparam logic [1:0] SrcMsg  = 2'b10;

  typedef enum logic [1:0] {
    IDLE_PAGE = 2'd0,
    SHOW_STAT = 2'd1,
    SHOW_MSG  = 2'd2,
    MSG_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ScanW-1:0]  scanCnt_q, scanCnt_d;
  logic [2:0]        nDigit_q, nDigit_d;
  logic [11:0]       dispValue_q, dispValue_d;
  logic [1:0]        dispSrc_q, dispSrc_d;
  logic [HoldW-1:0]  holdCnt_q, holdCnt_d;
  logic [11:0]       msgLatch_q, msgLatch_d;

  logic scanTick;
  logic frameEnd;

  // Digit-slot timing. The tick fires on the last count of each slot and
  // advances the anode rotation; a tick on the last digit closes the frame.
  always_comb begin
    scanTick  = (scanCnt_q == ScanLast);
    frameEnd  = scanTick && (nDigit_q == DigLo);
    scanCnt_d = scanTick ? '0 : scanCnt_q + 1'b1;
    nDigit_d  = nDigit_q;
    if (scanTick) begin
      case (nDigit_q)
        DigHi:   nDigit_d = DigMid;
        DigMid:  nDigit_d = DigLo;
        default: nDigit_d = DigHi;
      endcase
    end
  end

  // Source arbitration. A message is accepted only from IDLE_PAGE or
  // SHOW_STAT, which is why a request still held in MSG_DONE cannot
  // retrigger. The hold counter is loaded with HOLD_CYCLES-1 and the exit
  // happens on the edge that sees zero, so accept-to-ACK is exactly
  // HOLD_CYCLES cycles whatever the scan phase.
  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    msgLatch_d = msgLatch_q;
    case (state_q)
      IDLE_PAGE: begin
        if (MSG_REQ) begin
          state_d    = SHOW_MSG;
          msgLatch_d = MSG_DATA;
          holdCnt_d  = HoldLoad;
        end else if (STAT_REQ) begin
          state_d = SHOW_STAT;
        end
      end
      SHOW_STAT: begin
        if (MSG_REQ) begin
          state_d    = SHOW_MSG;
          msgLatch_d = MSG_DATA;
          holdCnt_d  = HoldLoad;
        end else if (!STAT_REQ) begin
          state_d = IDLE_PAGE;
        end
      end
      SHOW_MSG: begin
        if (holdCnt_q == '0) begin
          state_d = MSG_DONE;
        end else begin
          holdCnt_d = holdCnt_q - 1'b1;
        end
      end
      MSG_DONE: begin
        if (!MSG_REQ) begin
          state_d = STAT_REQ ? SHOW_STAT : IDLE_PAGE;
        end
      end
      default: state_d = IDLE_PAGE;
    endcase
  end

  // Frame-boundary load. The live sources are sampled only here, which is
  // what keeps a whole frame showing a single word.
  always_comb begin
    dispValue_d = dispValue_q;
    dispSrc_d   = dispSrc_q;
    if (frameEnd) begin
      case (state_q)
        SHOW_MSG, MSG_DONE: begin
          dispValue_d = msgLatch_q;
          dispSrc_d   = SrcMsg;
        end
        SHOW_STAT: begin
          dispValue_d = STAT_DATA;
          dispSrc_d   = SrcStat;
        end
        default: begin
          dispValue_d = PAGE_DATA;
          dispSrc_d   = SrcPage;
        end
      endcase
    end
  end

  // State registers; reset drops any in-flight message without an ACK.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE_PAGE;
      scanCnt_q   <= '0;
      nDigit_q    <= DigHi;
      dispValue_q <= 12'h000;
      dispSrc_q   <= SrcPage;
      holdCnt_q   <= '0;
      msgLatch_q  <= 12'h000;
    end else begin
      state_q     <= state_d;
      scanCnt_q   <= scanCnt_d;
      nDigit_q    <= nDigit_d;
      dispValue_q <= dispValue_d;
      dispSrc_q   <= dispSrc_d;
      holdCnt_q   <= holdCnt_d;
      msgLatch_q  <= msgLatch_d;
    end
  end

  // MSG_DONE is exactly the window in which the acknowledge is asserted.
  assign MSG_ACK    = (state_q == MSG_DONE);
  assign DISP_VALUE = dispValue_q;
  assign DISP_SRC   = dispSrc_q;
  assign nDIGIT     = nDigit_q;

  // Nibble select follows the anode that is currently driven.
  always_comb begin
    case (nDigit_q)
      DigHi:   DIGIT_NIBBLE = dispValue_q[11:8];
      DigMid:  DIGIT_NIBBLE = dispValue_q[7:4];
      DigLo:   DIGIT_NIBBLE = dispValue_q[3:0];
      default: DIGIT_NIBBLE = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fnd_display_scheduler
//
// Purpose:
//   Directed testbench for fnd_display_scheduler with SCAN_DIV=4 and
//   HOLD_CYCLES=20. Clock period is 10 ns; inputs are driven and outputs
//   sampled 1 ns after the rising edge. "aN" in the comments below means
//   "just after the N-th rising edge following reset release"; with
//   SCAN_DIV=4 the frame boundaries fall on edges that are multiples of 12.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fnd_display_scheduler;

  logic        MCLK;
  logic        nRESET;
  logic        MSG_REQ;
  logic [11:0] MSG_DATA;
  logic        MSG_ACK;
  logic        STAT_REQ;
  logic [11:0] STAT_DATA;
  logic [11:0] PAGE_DATA;
  logic [11:0] DISP_VALUE;
  logic [1:0]  DISP_SRC;
  logic [2:0]  nDIGIT;
  logic [3:0]  DIGIT_NIBBLE;

  int testsRun;
  int testsFailed;

  fnd_display_scheduler #(
    .SCAN_DIV    (4),
    .HOLD_CYCLES (20)
  ) dut (
    .MCLK         (MCLK),
    .nRESET       (nRESET),
    .MSG_REQ      (MSG_REQ),
    .MSG_DATA     (MSG_DATA),
    .MSG_ACK      (MSG_ACK),
    .STAT_REQ     (STAT_REQ),
    .STAT_DATA    (STAT_DATA),
    .PAGE_DATA    (PAGE_DATA),
    .DISP_VALUE   (DISP_VALUE),
    .DISP_SRC     (DISP_SRC),
    .nDIGIT       (nDIGIT),
    .DIGIT_NIBBLE (DIGIT_NIBBLE)
  );

  // Free-running 100 MHz bench clock.
  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  // Drives every requester input at once.
  task automatic applyStimulus(input logic msgReq, input logic [11:0] msgData,
                               input logic statReq, input logic [11:0] statData,
                               input logic [11:0] pageData);
    MSG_REQ   = msgReq;
    MSG_DATA  = msgData;
    STAT_REQ  = statReq;
    STAT_DATA = statData;
    PAGE_DATA = pageData;
  endtask

  // One comparison: counts it and reports a failure with its tag.
  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %03h expected %03h", tag, observed, expected);
    end
  endtask

  // Advances n rising edges and settles 1 ns past the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    nRESET      = 1'b0;
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 12'h123);

    // Reset values while nRESET is held low.
    #12;
    checkOutput("rst_ndigit",  12'(nDIGIT),       12'h003);
    checkOutput("rst_value",   DISP_VALUE,        12'h000);
    checkOutput("rst_src",     12'(DISP_SRC),     12'h000);
    checkOutput("rst_ack",     12'(MSG_ACK),      12'h000);
    checkOutput("rst_nibble",  12'(DIGIT_NIBBLE), 12'h000);
    #10;
    nRESET = 1'b1;

    // Page background and digit scan.
    waitCycles(1);   // a1
    checkOutput("scan_a1_ndigit", 12'(nDIGIT), 12'h003);
    checkOutput("scan_a1_value",  DISP_VALUE,  12'h000);
    waitCycles(3);   // a4
    checkOutput("scan_a4_ndigit", 12'(nDIGIT), 12'h005);
    waitCycles(4);   // a8
    checkOutput("scan_a8_ndigit", 12'(nDIGIT), 12'h006);
    checkOutput("scan_a8_value",  DISP_VALUE,  12'h000);
    waitCycles(4);   // a12: first frame boundary
    checkOutput("page_a12_ndigit", 12'(nDIGIT),       12'h003);
    checkOutput("page_a12_value",  DISP_VALUE,        12'h123);
    checkOutput("page_a12_src",    12'(DISP_SRC),     12'h000);
    checkOutput("page_a12_nibble", 12'(DIGIT_NIBBLE), 12'h001);
    waitCycles(4);   // a16: middle digit, change the page word mid-frame
    checkOutput("page_a16_ndigit", 12'(nDIGIT),       12'h005);
    checkOutput("page_a16_nibble", 12'(DIGIT_NIBBLE), 12'h002);
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 12'h456);
    waitCycles(4);   // a20
    checkOutput("page_a20_ndigit", 12'(nDIGIT),       12'h006);
    checkOutput("page_a20_value",  DISP_VALUE,        12'h123);
    checkOutput("page_a20_nibble", 12'(DIGIT_NIBBLE), 12'h003);
    waitCycles(3);   // a23
    checkOutput("page_a23_value",  DISP_VALUE, 12'h123);
    waitCycles(1);   // a24: boundary picks up the new page
    checkOutput("page_a24_value",  DISP_VALUE,        12'h456);
    checkOutput("page_a24_ndigit", 12'(nDIGIT),       12'h003);
    checkOutput("page_a24_nibble", 12'(DIGIT_NIBBLE), 12'h004);

    // Status request held 30 cycles.
    applyStimulus(1'b0, 12'h000, 1'b1, 12'h0A7, 12'h456);
    waitCycles(11);  // a35
    checkOutput("stat_a35_value", DISP_VALUE,    12'h456);
    checkOutput("stat_a35_src",   12'(DISP_SRC), 12'h000);
    waitCycles(1);   // a36
    checkOutput("stat_a36_value", DISP_VALUE,    12'h0A7);
    checkOutput("stat_a36_src",   12'(DISP_SRC), 12'h001);
    waitCycles(18);  // a54
    checkOutput("stat_a54_value", DISP_VALUE,    12'h0A7);
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h0A7, 12'h456);
    waitCycles(5);   // a59
    checkOutput("stat_a59_src",   12'(DISP_SRC), 12'h001);
    waitCycles(1);   // a60
    checkOutput("stat_a60_value", DISP_VALUE,    12'h456);
    checkOutput("stat_a60_src",   12'(DISP_SRC), 12'h000);

    // Message and status together; message accepted at edge 61.
    applyStimulus(1'b1, 12'hE01, 1'b1, 12'h0A7, 12'h456);
    waitCycles(1);   // a61
    checkOutput("msg1_a61_ack", 12'(MSG_ACK), 12'h000);
    applyStimulus(1'b1, 12'h999, 1'b1, 12'h0A7, 12'h456);
    waitCycles(11);  // a72
    checkOutput("msg1_a72_value", DISP_VALUE,    12'hE01);
    checkOutput("msg1_a72_src",   12'(DISP_SRC), 12'h002);
    waitCycles(8);   // a80
    checkOutput("msg1_a80_ack", 12'(MSG_ACK), 12'h000);
    waitCycles(1);   // a81: 20 cycles after accept
    checkOutput("msg1_a81_ack", 12'(MSG_ACK), 12'h001);
    waitCycles(4);   // a85
    checkOutput("msg1_a85_ack",   12'(MSG_ACK),  12'h001);
    checkOutput("msg1_a85_value", DISP_VALUE,    12'hE01);
    checkOutput("msg1_a85_src",   12'(DISP_SRC), 12'h002);
    applyStimulus(1'b0, 12'h999, 1'b1, 12'h0A7, 12'h456);
    waitCycles(1);   // a86
    checkOutput("msg1_a86_ack", 12'(MSG_ACK), 12'h000);
    waitCycles(9);   // a95
    checkOutput("msg1_a95_value", DISP_VALUE, 12'hE01);
    waitCycles(1);   // a96: status follows the message
    checkOutput("msg1_a96_value", DISP_VALUE,    12'h0A7);
    checkOutput("msg1_a96_src",   12'(DISP_SRC), 12'h001);

    // One-cycle request pulse; accepted at edge 98.
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h0A7, 12'h456);
    waitCycles(1);   // a97
    applyStimulus(1'b1, 12'hE02, 1'b0, 12'h0A7, 12'h456);
    waitCycles(1);   // a98
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h0A7, 12'h456);
    waitCycles(10);  // a108
    checkOutput("msg2_a108_value", DISP_VALUE,    12'hE02);
    checkOutput("msg2_a108_src",   12'(DISP_SRC), 12'h002);
    waitCycles(9);   // a117
    checkOutput("msg2_a117_ack", 12'(MSG_ACK), 12'h000);
    waitCycles(1);   // a118
    checkOutput("msg2_a118_ack", 12'(MSG_ACK), 12'h001);
    waitCycles(1);   // a119
    checkOutput("msg2_a119_ack", 12'(MSG_ACK), 12'h000);
    waitCycles(1);   // a120
    checkOutput("msg2_a120_value", DISP_VALUE,    12'h456);
    checkOutput("msg2_a120_src",   12'(DISP_SRC), 12'h000);

    // Message accepted at edge 126, reset 10 cycles before its ACK.
    waitCycles(5);   // a125
    applyStimulus(1'b1, 12'hE03, 1'b0, 12'h0A7, 12'h456);
    waitCycles(1);   // a126
    checkOutput("msg3_a126_ack", 12'(MSG_ACK), 12'h000);
    waitCycles(6);   // a132
    checkOutput("msg3_a132_value", DISP_VALUE,    12'hE03);
    checkOutput("msg3_a132_src",   12'(DISP_SRC), 12'h002);
    waitCycles(4);   // a136
    checkOutput("msg3_a136_ndigit", 12'(nDIGIT), 12'h005);
    nRESET = 1'b0;
    #2;
    checkOutput("mrst_ndigit", 12'(nDIGIT),       12'h003);
    checkOutput("mrst_value",  DISP_VALUE,        12'h000);
    checkOutput("mrst_src",    12'(DISP_SRC),     12'h000);
    checkOutput("mrst_ack",    12'(MSG_ACK),      12'h000);
    checkOutput("mrst_nibble", 12'(DIGIT_NIBBLE), 12'h000);
    for (int i = 0; i < 15; i++) begin
      waitCycles(1);
      checkOutput("mrst_held_ack", 12'(MSG_ACK), 12'h000);
    end
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h0A7, 12'h456);
    nRESET = 1'b1;
    for (int i = 0; i < 11; i++) begin
      waitCycles(1);
      checkOutput("mrst_post_ack", 12'(MSG_ACK), 12'h000);
    end
    checkOutput("mrst_q11_value", DISP_VALUE, 12'h000);
    waitCycles(1);
    checkOutput("mrst_q12_value", DISP_VALUE,    12'h456);
    checkOutput("mrst_q12_src",   12'(DISP_SRC), 12'h000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
